// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK carrier NCO: quadrant codes, the pi address offset,
// the output amplitude and the default quarter-table image path.
package bpsk_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

    localparam DEFAULT_INIT_FILE = "assets/sources/sin_quarter.hex";

    // Half a full-wave table: adding this to an address shifts the carrier by 180 degrees.
    function automatic int unsigned pi_offset(input int unsigned addr_w);
        return 32'd1 << (addr_w - 1);
    endfunction

    function automatic int unsigned amplitude(input int unsigned data_w);
        return (32'd1 << (data_w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/sin_nco_if.sv
// Control and sample bus of the sine NCO; the driver side is the master, the NCO the slave.
interface sin_nco_if #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8
);
    logic                      en_sig;
    logic [PHASE_W-1:0]        fcw_sig;
    logic                      fcw_load_sig;
    logic [ADDR_W-1:0]         phase_ofs_sig;
    logic                      bpsk_sym_sig;
    logic signed [DATA_W-1:0]  sin_sig;
    logic                      valid_sig;
    logic [PHASE_W-1:0]        phase_sig;

    modport master (
        output en_sig, fcw_sig, fcw_load_sig, phase_ofs_sig, bpsk_sym_sig,
        input  sin_sig, valid_sig, phase_sig
    );

    modport slave (
        input  en_sig, fcw_sig, fcw_load_sig, phase_ofs_sig, bpsk_sym_sig,
        output sin_sig, valid_sig, phase_sig
    );
endinterface

// File: rtl/quarter_sin_rom.sv
// Quarter-wave sine magnitude table with a registered read (S2 of the NCO pipeline).
// T[k] = round(A*sin(2*pi*(k+0.5)/2^(IDX_W+2))); the output register holds while rd_en_i is low.
module quarter_sin_rom
    import bpsk_pkg::*;
#(
    parameter int IDX_W     = 8,
    parameter int VAL_W     = 7,
    parameter     INIT_FILE = DEFAULT_INIT_FILE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [VAL_W-1:0] dat_o
);
    localparam int NENT = 1 << IDX_W;
    localparam int FX   = 30;
    localparam longint PI_FX = 64'sd3373259426;
    // Contents are generated at elaboration; INIT_FILE only names the equivalent hex image.
    localparam int unused_init_file_w = $bits(INIT_FILE);

    function automatic int unsigned entry(input int k);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (PI_FX * longint'(2 * k + 1)) >>> (IDX_W + 2);
        x2   = (x * x) >>> FX;
        term = x;
        sum  = x;
        for (int n = 1; n <= 7; n++) begin
            term = -((term * x2) / (longint'(2 * n * (2 * n + 1)) <<< FX));
            sum  = sum + term;
        end
        return 32'((longint'(amplitude(VAL_W + 1)) * sum + (longint'(1) <<< (FX - 1))) >>> FX);
    endfunction

    logic [VAL_W-1:0] table_w [NENT];

    for (genvar k = 0; k < NENT; k++) begin : g_entry
        localparam logic [VAL_W-1:0] VAL = VAL_W'(entry(k));
        assign table_w[k] = VAL;
    end

    logic [VAL_W-1:0] dat_q, dat_d;

    always_comb begin
        dat_d = dat_q;
        if (rd_en_i) dat_d = table_w[idx_i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dat_q <= '0;
        else     dat_q <= dat_d;
    end

    assign dat_o = dat_q;
endmodule

// File: rtl/sin_nco.sv
// Phase-accumulator NCO with a 3-stage valid-tagged quarter-wave sine pipeline and BPSK flip.
// en at edge n gives valid_sig and its sample after edge n+2; stages without valid input hold.
module sin_nco
    import bpsk_pkg::*;
#(
    parameter int PHASE_W   = 32,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter     INIT_FILE = DEFAULT_INIT_FILE
) (
    input  logic      clk,
    input  logic      rst,
    sin_nco_if.slave  bus
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int VAL_W = DATA_W - 1;
    localparam logic [ADDR_W-1:0] PI_OFS = ADDR_W'(pi_offset(ADDR_W));

    logic [PHASE_W-1:0]       fcw_q, fcw_d;
    logic [PHASE_W-1:0]       acc_q, acc_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     neg_q, neg_d;
    logic [2:0]               vld_q, vld_d;
    logic signed [DATA_W-1:0] sin_q, sin_d;

    quad_e            quad_w;
    logic             mirror_w;
    logic [IDX_W-1:0] idx_w;
    logic [VAL_W-1:0] mag_w;

    assign quad_w   = quad_e'(addr_q[ADDR_W-1 -: 2]);
    assign mirror_w = (quad_w == Q1) || (quad_w == Q3);
    assign idx_w    = mirror_w ? ~addr_q[IDX_W-1:0] : addr_q[IDX_W-1:0];

    always_comb begin
        fcw_d  = fcw_q;
        acc_d  = acc_q;
        addr_d = addr_q;
        neg_d  = neg_q;
        sin_d  = sin_q;
        vld_d  = {vld_q[1:0], bus.en_sig};

        if (bus.fcw_load_sig) fcw_d = bus.fcw_sig;

        // Both the accumulator step and the S1 address use the values from before this edge.
        if (bus.en_sig) begin
            acc_d  = acc_q + fcw_q;
            addr_d = acc_q[PHASE_W-1 -: ADDR_W] + bus.phase_ofs_sig
                   + (bus.bpsk_sym_sig ? PI_OFS : '0);
        end

        if (vld_q[0]) neg_d = (quad_w == Q2) || (quad_w == Q3);

        if (vld_q[1]) sin_d = neg_q ? -$signed({1'b0, mag_w}) : $signed({1'b0, mag_w});
    end

    quarter_sin_rom #(
        .IDX_W     (IDX_W),
        .VAL_W     (VAL_W),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clk     (clk),
        .rst     (rst),
        .rd_en_i (vld_q[0]),
        .idx_i   (idx_w),
        .dat_o   (mag_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcw_q  <= '0;
            acc_q  <= '0;
            addr_q <= '0;
            neg_q  <= 1'b0;
            vld_q  <= '0;
            sin_q  <= '0;
        end else begin
            fcw_q  <= fcw_d;
            acc_q  <= acc_d;
            addr_q <= addr_d;
            neg_q  <= neg_d;
            vld_q  <= vld_d;
            sin_q  <= sin_d;
        end
    end

    assign bus.sin_sig   = sin_q;
    assign bus.valid_sig = vld_q[2];
    assign bus.phase_sig = acc_q;
endmodule

// File: tb/tb_sin_nco.sv
// Bench for sin_nco: a reference model pushes expected samples at launch, a monitor pops them on valid_sig.
module tb_sin_nco;
    localparam int PHASE_W = 32;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam real TWO_PI = 6.283185307179586;

    logic clk;
    logic rst;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_acc = '0;
    logic [31:0] m_fcw = '0;
    int exp_q[$];
    int last_exp = 0;
    int mon_e;

    sin_nco_if #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sin_nco #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sin_ref(input int a);
        real x;
        x = 127.0 * $sin(TWO_PI * (real'(a) + 0.5) / 1024.0);
        if (x < 0.0) return -$rtoi(0.5 - x);
        return $rtoi(x + 0.5);
    endfunction

    // One clock; afterwards update the model with the inputs that were applied at that edge.
    task automatic tick();
        int a;
        @(posedge clk);
        #1;
        if (rst) begin
            m_acc    = '0;
            m_fcw    = '0;
            last_exp = 0;
            exp_q.delete();
        end else begin
            if (bus.en_sig) begin
                a = (int'(m_acc[31:22]) + int'(bus.phase_ofs_sig) + (bus.bpsk_sym_sig ? 512 : 0)) % 1024;
                exp_q.push_back(sin_ref(a));
                m_acc = m_acc + m_fcw;
            end
            if (bus.fcw_load_sig) m_fcw = bus.fcw_sig;
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            checks++;
            if (bus.valid_sig) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: valid_sig=1 sin_sig=%0d but no sample was launched", bus.sin_sig);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (int'(bus.sin_sig) !== mon_e) begin
                        errors++;
                        $display("FAIL sb_sample: sin_sig=%0d expected %0d", bus.sin_sig, mon_e);
                    end
                    last_exp = mon_e;
                end
            end else if (int'(bus.sin_sig) !== last_exp) begin
                errors++;
                $display("FAIL sin_hold: sin_sig=%0d expected held %0d", bus.sin_sig, last_exp);
            end
        end
    end

    task automatic do_reset();
        bus.en_sig        = 1'b0;
        bus.fcw_load_sig  = 1'b0;
        bus.bpsk_sym_sig  = 1'b0;
        bus.phase_ofs_sig = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_fcw(input logic [31:0] v);
        bus.fcw_sig      = v;
        bus.fcw_load_sig = 1'b1;
        tick();
        bus.fcw_load_sig = 1'b0;
    endtask

    task automatic test_reset();
        bus.en_sig        = 1'b1;
        bus.fcw_sig       = 32'h0040_0000;
        bus.fcw_load_sig  = 1'b1;
        bus.phase_ofs_sig = '0;
        bus.bpsk_sym_sig  = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks += 3;
            if (bus.sin_sig !== '0) begin errors++; $display("FAIL rst_sin: got %0d expected 0", bus.sin_sig); end
            if (bus.valid_sig !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", bus.valid_sig); end
            if (bus.phase_sig !== '0) begin errors++; $display("FAIL rst_phase: got %h expected 0", bus.phase_sig); end
        end
        bus.en_sig       = 1'b0;
        bus.fcw_load_sig = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks += 3;
            if (bus.sin_sig !== '0) begin errors++; $display("FAIL post_rst_sin: got %0d expected 0", bus.sin_sig); end
            if (bus.valid_sig !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %0b expected 0", bus.valid_sig); end
            if (bus.phase_sig !== '0) begin errors++; $display("FAIL post_rst_phase: got %h expected 0", bus.phase_sig); end
        end
    endtask

    task automatic test_unit_step();
        int samp[$];
        int pos[5] = '{0, 256, 512, 768, 1024};
        int ev[5]  = '{0, 127, 0, -127, 0};
        load_fcw(32'h0040_0000);
        bus.en_sig = 1'b1;
        for (int k = 0; k < 1027; k++) begin
            tick();
            if (bus.valid_sig) samp.push_back(int'(bus.sin_sig));
            if (k <= 2) begin
                checks++;
                if (bus.valid_sig !== 1'(k == 2)) begin
                    errors++;
                    $display("FAIL step_latency: edge %0d valid_sig=%0b expected %0b", k, bus.valid_sig, (k == 2));
                end
            end
            if (k == 1022) begin
                checks++;
                if (bus.phase_sig !== 32'hFFC0_0000) begin errors++; $display("FAIL step_phase_top: got %h expected ffc00000", bus.phase_sig); end
            end
            if (k == 1023) begin
                checks++;
                if (bus.phase_sig !== 32'h0) begin errors++; $display("FAIL step_phase_wrap: got %h expected 0", bus.phase_sig); end
            end
        end
        bus.en_sig = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.valid_sig) samp.push_back(int'(bus.sin_sig));
        end
        checks++;
        if (samp.size() != 1027) begin errors++; $display("FAIL step_count: got %0d samples expected 1027", samp.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (samp.size() <= pos[i]) begin
                errors++;
                $display("FAIL step_sample: sample %0d missing expected %0d", pos[i], ev[i]);
            end else if (samp[pos[i]] !== ev[i]) begin
                errors++;
                $display("FAIL step_sample: sample %0d got %0d expected %0d", pos[i], samp[pos[i]], ev[i]);
            end
        end
    endtask

    task automatic test_bpsk_flip();
        int samp[$];
        int base[4] = '{0, 127, 0, -127};
        int e;
        do_reset();
        load_fcw(32'h4000_0000);
        for (int k = 0; k < 19; k++) begin
            bus.en_sig       = (k < 16);
            bus.bpsk_sym_sig = (k >= 8) && (k < 16);
            tick();
            if (bus.valid_sig) samp.push_back(int'(bus.sin_sig));
        end
        bus.bpsk_sym_sig = 1'b0;
        checks++;
        if (samp.size() != 16) begin errors++; $display("FAIL bpsk_count: got %0d samples expected 16", samp.size()); end
        for (int k = 0; k < 16 && k < samp.size(); k++) begin
            e = (k < 8) ? base[k % 4] : -base[k % 4];
            checks++;
            if (samp[k] !== e) begin errors++; $display("FAIL bpsk_sample: sample %0d got %0d expected %0d", k, samp[k], e); end
        end
    endtask

    task automatic test_fcw_collision();
        logic [31:0] ep[3] = '{32'h0040_0000, 32'h00C0_0000, 32'h0140_0000};
        do_reset();
        load_fcw(32'h0040_0000);
        bus.en_sig       = 1'b1;
        bus.fcw_sig      = 32'h0080_0000;
        bus.fcw_load_sig = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.fcw_load_sig = 1'b0;
            checks++;
            if (bus.phase_sig !== ep[k]) begin errors++; $display("FAIL fcw_collision: step %0d phase %h expected %h", k, bus.phase_sig, ep[k]); end
        end
        bus.en_sig = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_bubbles();
        bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int n_en = 0;
        bit ev;
        do_reset();
        load_fcw(32'h0400_0000);
        bus.phase_ofs_sig = 10'd37;
        for (int k = 0; k < 9; k++) begin
            bus.en_sig = (k < 5) ? pat[k] : 1'b0;
            tick();
            if (k < 5 && pat[k]) n_en++;
            ev = 1'b0;
            if (k >= 2 && k <= 6) ev = pat[k - 2];
            checks += 2;
            if (bus.valid_sig !== ev) begin errors++; $display("FAIL bubble_valid: edge %0d got %0b expected %0b", k, bus.valid_sig, ev); end
            if (bus.phase_sig !== 32'(n_en * (1 << 26))) begin
                errors++;
                $display("FAIL bubble_phase: edge %0d got %h expected %h", k, bus.phase_sig, 32'(n_en * (1 << 26)));
            end
        end
        bus.phase_ofs_sig = '0;
    endtask

    task automatic test_midstream_reset();
        do_reset();
        load_fcw(32'h0100_0000);
        bus.phase_ofs_sig = 10'd100;
        bus.en_sig = 1'b1;
        repeat (3) tick();
        bus.en_sig = 1'b0;
        #3;
        rst = 1'b1;
        exp_q.delete();
        last_exp = 0;
        #1;
        checks += 3;
        if (bus.sin_sig !== '0) begin errors++; $display("FAIL async_rst_sin: got %0d expected 0", bus.sin_sig); end
        if (bus.valid_sig !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %0b expected 0", bus.valid_sig); end
        if (bus.phase_sig !== '0) begin errors++; $display("FAIL async_rst_phase: got %h expected 0", bus.phase_sig); end
        tick();
        #3;
        rst = 1'b0;
        bus.phase_ofs_sig = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (bus.valid_sig !== 1'b0) begin errors++; $display("FAIL async_rst_ghost: cycle %0d valid_sig=%0b expected 0", k, bus.valid_sig); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.en_sig        = 1'b0;
        bus.fcw_sig       = '0;
        bus.fcw_load_sig  = 1'b0;
        bus.phase_ofs_sig = '0;
        bus.bpsk_sym_sig  = 1'b0;
        test_reset();
        test_unit_step();
        test_bpsk_flip();
        test_fcw_collision();
        test_bubbles();
        test_midstream_reset();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: %0d samples never produced, expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sin_nco.md
# sin_nco

Parametrised numerically controlled oscillator for the BPSK modulator: a phase accumulator drives a pipelined, quarter-wave-compressed sine table and produces one signed carrier sample per enabled clock. It replaces the flat combinational full-wave sine ROM. It adds:
- programmable frequency and phase offset;
- an exact 180° BPSK symbol flip;
- a valid-tagged 3-stage pipeline.

## Interface
- PHASE_W, 32: phase accumulator width (PHASE_W ≥ ADDR_W).
- ADDR_W, 10: full-wave table address width; the stored quarter table holds 2^(ADDR_W-2) entries (ADDR_W ≥ 3).
- DATA_W, 8: signed output width; amplitude A = 2^(DATA_W-1)-1.
- INIT_FILE, "assets/sources/sin_quarter.hex": $readmemh image of the quarter table.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en_sig  in  1  advance the accumulator and launch one sample.
- fcw_sig  in  PHASE_W  frequency control word.
- fcw_load_sig  in  1  capture fcw_sig into the internal FCW register.
- phase_ofs_sig  in  ADDR_W  static phase offset, in table-address units.
- bpsk_sym_sig  in  1  1 = add π to the launched sample.
- sin_sig  out  DATA_W  signed two's-complement sample.
- valid_sig  out  1  sin_sig carries a new sample this cycle.
- phase_sig  out  PHASE_W  current accumulator value.

## Operation
- **FCW register:** loads fcw_sig on an edge where fcw_load_sig=1.
- **Accumulator:** on each edge with en_sig=1, acc ← acc + fcw_reg, modulo 2^PHASE_W (wraps silently).
  - The sum uses fcw_reg as it was before that edge, so load and en in the same cycle applies the new FCW from the next enabled edge.
- **S1 (address):** on an en_sig=1 edge, register a = acc[PHASE_W-1 -: ADDR_W] + phase_ofs_sig + (bpsk_sym_sig ? 2^(ADDR_W-1) : 0), modulo 2^ADDR_W.
  - The pre-increment acc is used.
  - Split a into quadrant q = a[ADDR_W-1:ADDR_W-2] and index i = a[ADDR_W-3:0].
- **S2 (table read):** registered read of T[q[0] ? ~i : i]; carry neg = q[1].
- **S3 (output):** sin_sig ← neg ? -T : T. The result is always representable because T ≤ A.
- **Table contents:** T[k] = round(A·sin(2π(k+0.5)/2^ADDR_W)), k = 0 … 2^(ADDR_W-2)-1, all values non-negative.
  - The half-sample offset makes the ~i mirror exact, so no extra peak entry is needed.
- **Valid pipeline:** a 3-bit valid shift register advances every clock with en_sig as its input; valid_sig is the last bit.
- **Bubbles:** a data stage loads only when its incoming valid bit is 1. When valid_sig=0, sin_sig holds its last value.
- **BPSK flip:** bpsk_sym_sig and phase_ofs_sig are sampled on the same edge as the address. A symbol change therefore affects exactly the samples launched from that edge onward; no glitch samples appear.
- **Reset values:** acc, fcw_reg, all stage registers, sin_sig, phase_sig and valid_sig are all 0.
- **Reset mid-stream:** clears immediately and asynchronously; in-flight samples are discarded and no valid_sig pulse follows reset release.

## Timing
- **Latency:** en_sig=1 at edge n → valid_sig=1 and the corresponding sin_sig in the cycle after edge n+2 (3 cycles).
- **Throughput:** one sample per clock with en_sig held high.
- **phase_sig:** updates in the cycle after each enabled edge.
- **Critical paths:** the accumulator adder (PHASE_W) and the S1 3-input ADDR_W adder. Both are registered, with no combinational path from inputs to outputs.

## Structure
- **Package bpsk_pkg:**
  - quadrant encodings (Q0..Q3);
  - function for the π offset 2^(ADDR_W-1);
  - amplitude constant A(DATA_W);
  - default INIT_FILE path.
- **Sub-module quarter_sin_rom:**
  - parameters ADDR_W-2 and DATA_W-1, with INIT_FILE passed through;
  - registered read, with read enable = S1 valid;
  - it is the S2 register.
- **Top level:** sin_nco holds the FCW register, accumulator, S1, S3 and the valid shift register.

## Test plan
Defaults throughout: PHASE_W=32, ADDR_W=10, DATA_W=8, A=127, 256-entry table.
1. **Reset:** rst pulse with en_sig=1 → sin_sig=0, valid_sig=0, phase_sig=0 during reset and for 3 cycles after release with en_sig=0.
2. **Unit step:** fcw=2^22, en_sig held → valid after 3 cycles. Samples 0, 256, 512, 768 (first valid counted as 0) = 0, 127, 0, -127; period 1024 samples; phase_sig wraps to 0 after 1024 enables.
3. **BPSK flip:** fcw=2^30 → sequence 0, 127, 0, -127 repeating. Toggle bpsk_sym_sig at launch k → samples from k onward equal the negation of the unflipped sequence, with no intermediate value.
4. **FCW load collision:** fcw_load_sig=1 with fcw_sig=2^23 in the same cycle as en_sig, old fcw=2^22 → that edge adds 2^22, following edges add 2^23 (phase_sig steps checked).
5. **Bubbles:** en_sig pattern 1,0,1,1,0 → valid_sig shows the same pattern 3 cycles later; sin_sig holds during gaps; acc is unchanged on en_sig=0 edges.
6. **Mid-stream reset:** async rst asserted between edges while 3 samples are in flight → outputs clear immediately; after release with en_sig=0, no valid_sig ever asserts.
